// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the alarm clock sequencer: state encodings, counter
// moduli defaults, counter widths and the button arbitration helper.
package clock_ctrl_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam int SEC_MAX_DEF   = 60;
  localparam int MIN_MAX_DEF   = 60;
  localparam int HR_MAX_DEF    = 24;
  localparam int RING_SECS_DEF = 60;

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_SET_T_HR  = 3'd1;
  localparam logic [2:0] ST_SET_T_MIN = 3'd2;
  localparam logic [2:0] ST_SET_A_HR  = 3'd3;
  localparam logic [2:0] ST_SET_A_MIN = 3'd4;

  typedef enum logic [2:0] {
    BTN_NONE = 3'd0,
    BTN_C    = 3'd1,
    BTN_R    = 3'd2,
    BTN_L    = 3'd3,
    BTN_U    = 3'd4,
    BTN_D    = 3'd5
  } btn_t;

  // Only the highest-priority press counts; up and down together cancel.
  function automatic btn_t pick_button(input logic c, input logic r,
                                       input logic l, input logic u,
                                       input logic d);
    btn_t b;
    if (c)             b = BTN_C;
    else if (r)        b = BTN_R;
    else if (l)        b = BTN_L;
    else if (u && !d)  b = BTN_U;
    else if (d && !u)  b = BTN_D;
    else               b = BTN_NONE;
    return b;
  endfunction

endpackage

// File: rtl/clock_mode_controller_alarm_ringer.sv
// Alarm ringer: fires once on the rising edge of a time match and self-clears
// after RING_SECS ticks, on an explicit clear, or when the alarm is disarmed.
module alarm_ringer
  import clock_ctrl_pkg::*;
#(
  parameter int RING_SECS = RING_SECS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic match,
  input  logic tick,
  input  logic clear,
  input  logic armed,
  output logic ring
);

  localparam int CW = $clog2(RING_SECS + 1);

  logic [CW-1:0] ring_cnt;
  logic          match_q;

  // Clearing beats a fresh match so a disarm can never leave the bell on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q  <= 1'b0;
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else begin
      match_q <= match;
      if (clear || !armed) begin
        ring     <= 1'b0;
        ring_cnt <= '0;
      end else if (match && !match_q) begin
        ring     <= 1'b1;
        ring_cnt <= '0;
      end else if (ring && tick) begin
        if (ring_cnt == CW'(RING_SECS - 1)) begin
          ring     <= 1'b0;
          ring_cnt <= '0;
        end else begin
          ring_cnt <= ring_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// Alarm clock sequencer: run/set mode FSM, arm control, and the per-counter
// enable and shared direction decode driven by tick and button pulses.
module clock_mode_controller
  import clock_ctrl_pkg::*;
#(
  parameter int SEC_MAX   = SEC_MAX_DEF,
  parameter int MIN_MAX   = MIN_MAX_DEF,
  parameter int HR_MAX    = HR_MAX_DEF,
  parameter int RING_SECS = RING_SECS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_c,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic [SEC_W-1:0] sec,
  input  logic [MIN_W-1:0] min,
  input  logic [HR_W-1:0]  hr,
  input  logic [MIN_W-1:0] al_min,
  input  logic [HR_W-1:0]  al_hr,
  output logic             sec_en,
  output logic             min_en,
  output logic             hr_en,
  output logic             al_min_en,
  output logic             al_hr_en,
  output logic             cnt_up,
  output logic             cnt_down,
  output logic [2:0]       mode,
  output logic             armed,
  output logic             alarm_ring
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       armed_nxt;
  btn_t       btn;
  logic       any_btn;
  logic       ring_clr;
  logic       match;

  assign btn     = pick_button(btn_c, btn_r, btn_l, btn_u, btn_d);
  assign any_btn = btn_c | btn_l | btn_r | btn_u | btn_d;

  // While ringing in RUN, any press only silences the bell.
  assign ring_clr = (state == ST_RUN) && alarm_ring && any_btn;

  assign match = (state == ST_RUN) && armed && (sec == '0) &&
                 (min == al_min) && (hr == al_hr) && (hr < HR_W'(HR_MAX));

  assign mode = state;

  always_comb begin
    state_nxt = state;
    armed_nxt = armed;
    case (state)
      ST_RUN: begin
        if (!ring_clr) begin
          case (btn)
            BTN_C:   state_nxt = ST_SET_T_HR;
            BTN_U:   armed_nxt = 1'b1;
            BTN_D:   armed_nxt = 1'b0;
            default: ;
          endcase
        end
      end
      ST_SET_T_HR, ST_SET_T_MIN, ST_SET_A_HR, ST_SET_A_MIN: begin
        case (btn)
          BTN_C: state_nxt = ST_RUN;
          BTN_R: begin
            case (state)
              ST_SET_T_HR:  state_nxt = ST_SET_T_MIN;
              ST_SET_T_MIN: state_nxt = ST_SET_A_HR;
              ST_SET_A_HR:  state_nxt = ST_SET_A_MIN;
              default:      state_nxt = ST_SET_T_HR;
            endcase
          end
          BTN_L: begin
            case (state)
              ST_SET_T_HR:  state_nxt = ST_SET_A_MIN;
              ST_SET_A_MIN: state_nxt = ST_SET_A_HR;
              ST_SET_A_HR:  state_nxt = ST_SET_T_MIN;
              default:      state_nxt = ST_SET_T_HR;
            endcase
          end
          default: ;
        endcase
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= armed_nxt;
    end
  end

  // Ticks only advance time in RUN; in SET states up/down adjust the selected counter.
  always_comb begin
    sec_en    = 1'b0;
    min_en    = 1'b0;
    hr_en     = 1'b0;
    al_min_en = 1'b0;
    al_hr_en  = 1'b0;
    cnt_up    = 1'b0;
    cnt_down  = 1'b0;
    if (!reset) begin
      if (state == ST_RUN) begin
        if (tick) begin
          sec_en = 1'b1;
          cnt_up = 1'b1;
          if (sec == SEC_W'(SEC_MAX - 1)) begin
            min_en = 1'b1;
            if (min == MIN_W'(MIN_MAX - 1)) hr_en = 1'b1;
          end
        end
      end else if (btn == BTN_U || btn == BTN_D) begin
        cnt_up   = (btn == BTN_U);
        cnt_down = (btn == BTN_D);
        case (state)
          ST_SET_T_HR:  hr_en     = 1'b1;
          ST_SET_T_MIN: min_en    = 1'b1;
          ST_SET_A_HR:  al_hr_en  = 1'b1;
          ST_SET_A_MIN: al_min_en = 1'b1;
          default: ;
        endcase
      end
    end
  end

  alarm_ringer #(
    .RING_SECS(RING_SECS)
  ) u_ringer (
    .clk  (clk),
    .reset(reset),
    .match(match),
    .tick (tick),
    .clear(ring_clr),
    .armed(armed),
    .ring (alarm_ring)
  );

endmodule

// File: doc/clock_mode_controller.md
# clock_mode_controller

Central sequencer for the alarm clock's mod-n up/down counters: seconds, minutes, hours, alarm minutes and alarm hours. Turns a 1 Hz tick and five debounced push-button pulses into per-counter enable strobes and a shared up/down direction. It also runs the run/set mode state machine, arms the alarm, and drives the ringing output. It sits between the button debouncers and tick divider on one side and the counter instances on the other.

## Interface
- SEC_MAX, 60, seconds modulus; tick rolls seconds at SEC_MAX-1
- MIN_MAX, 60, minutes modulus (time and alarm)
- HR_MAX, 24, hours modulus (time and alarm)
- RING_SECS, 60, ticks after which a ringing alarm self-clears
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  1 Hz pulse, exactly one clk cycle wide
- btn_c, btn_l, btn_r, btn_u, btn_d  in  1 each  debounced single-cycle button pulses
- sec, min, hr  in  6/6/5  current time counter values
- al_min, al_hr  in  6/5  current alarm counter values
- sec_en, min_en, hr_en, al_min_en, al_hr_en  out  1 each  counter enables
- cnt_up, cnt_down  out  1 each  shared direction to all counters; never both 1
- mode  out  3  current state encoding
- armed  out  1  alarm armed
- alarm_ring  out  1  alarm sounding

## Operation
- States: RUN=0, SET_T_HR=1, SET_T_MIN=2, SET_A_HR=3, SET_A_MIN=4.
- Button priority per cycle is c > r > l > u/d. Only the highest-priority button pressed in a cycle is acted upon.
- RUN transitions:
  - btn_c moves to SET_T_HR, unless alarm_ring is high.
  - btn_u sets armed; btn_d clears armed.
  - btn_l and btn_r are ignored.
- SET states transitions:
  - btn_c returns to RUN.
  - btn_r steps forward: T_HR→T_MIN→A_HR→A_MIN→T_HR.
  - btn_l steps in the reverse order.
- SET states adjustment:
  - btn_u alone drives the selected counter's enable plus cnt_up.
  - btn_d alone drives the selected counter's enable plus cnt_down.
  - btn_u and btn_d together: no action.
  - The counter's own wrap rules apply (0↔n-1).
- Tick in RUN:
  - sec_en=1 and cnt_up=1.
  - min_en=1 if sec==SEC_MAX-1.
  - hr_en=1 if additionally min==MIN_MAX-1.
- Tick in any SET state is dropped; time is frozen while setting.
- Alarm match is defined as: sec==0, min==al_min, hr==al_hr, armed=1, state RUN.
  - alarm_ring sets on the rising edge of match (registered match_q), so it fires once per match.
- alarm_ring clears on any of:
  - any button pulse in RUN; the button is consumed, with no arm or mode effect;
  - RING_SECS ticks elapsing;
  - armed being cleared.
- Reset values:
  - state RUN; armed, alarm_ring, match_q and ring counter 0.
  - All enables, cnt_up and cnt_down are forced to 0 while reset is high.

## Timing
- Enables and direction are combinational from the registered state and same-cycle tick/button. The counter updates on the next clk edge, so one-cycle latency from pulse to count.
- State change: a pulse at cycle k gives the new mode at k+1. A mode-changing button produces no enable in cycle k.
- Tick and button in the same RUN cycle: both are served. The tick drives the time enables; the button affects only armed/ring.
- Alarm: counts match at edge k gives match_q at k+1 and alarm_ring=1 at k+1. The ring counter counts ticks from that cycle.
- Entering a SET state while ringing is impossible, because btn_c clears the ring first.
- Asynchronous reset mid-ring or mid-set returns to RUN/idle immediately. Counters are not touched; they reset on their own.

## Structure
- Shared package clock_ctrl_pkg holds:
  - the state encodings;
  - the SEC_MAX/MIN_MAX/HR_MAX defaults;
  - the count widths (6/6/5).
- Sub-module alarm_ringer handles the match edge detect, the RING_SECS timeout counter and the ring set/clear. Its inputs are match, tick, clear and armed.
- Top level contains the mode FSM and the enable/direction decode.

## Test plan
- Rollover: state RUN, sec=59, min=59, hr=23 with a tick. Expect sec_en=min_en=hr_en=1 and cnt_up=1 that cycle; nothing on the next cycle without a tick.
- Mode walk: btn_c then btn_r ×4 then btn_l then btn_c. Expect mode 0→1→2→3→4→1→4→0, one step per cycle, no enables.
- Adjust: SET_A_MIN with btn_d gives al_min_en=1 and cnt_down=1. btn_u and btn_d together give all enables 0. A tick in SET_T_HR gives sec_en=0.
- Alarm: armed, al_hr=7, al_min=30. Time reaches 07:30:00 so alarm_ring=1 the next cycle. After 60 ticks it returns to 0, and it does not re-fire at 07:30:01.
- Silence: ringing with btn_c pulse. Expect alarm_ring=0, mode stays 0, armed stays 1.
- Reset mid-set: in SET_T_MIN assert reset with btn_u high. Expect mode=0, min_en=0 immediately, armed=0.
